// File: rtl/nw_pkg.sv
// Shared types and helpers for the NW score RAM write path.
package nw_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INIT_ROW = 2'd1,
        INIT_COL = 2'd2,
        RUN      = 2'd3
    } wr_state_t;

    localparam int SCORE_W_DEF = 9;

    // Row-major grid address; pitch is the row length including column 0.
    function automatic logic [31:0] grid_addr(input logic [31:0] row,
                                              input logic [31:0] col,
                                              input logic [31:0] pitch);
        return row * pitch + col;
    endfunction

endpackage

// File: rtl/score_addr_calc.sv
// Combinational (row, col) to score RAM address mapping, pitch M+1.
module score_addr_calc
    import nw_pkg::*;
#(
    parameter int M      = 128,
    parameter int ROW_W  = 8,
    parameter int COL_W  = 8,
    parameter int ADDR_W = 15
) (
    input  logic [ROW_W:0]    row,
    input  logic [COL_W:0]    col,
    output logic [ADDR_W-1:0] addr
);

    assign addr = ADDR_W'(grid_addr(32'(row), 32'(col), 32'(M + 1)));

endmodule

// File: rtl/score_ram_writer.sv
// Score RAM write-port front end: boundary init sequencer plus cell write path.
// Optional macro SCORE_WR_BOUNDS_CHK_EN drops out-of-range cells and raises sticky err.
//
// state    | meaning
// IDLE     | waiting for start_init, write port quiet
// INIT_ROW | writing row 0, columns 0..M
// INIT_COL | writing column 0, rows 1..N
// RUN      | accepting cell writes
module score_ram_writer
    import nw_pkg::*;
#(
    parameter int N       = 128,
    parameter int M       = 128,
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int GAP     = -2,
    parameter int ROW_W   = $clog2(N + 1),
    parameter int COL_W   = $clog2(M + 1),
    parameter int ADDR_W  = $clog2((N + 1) * (M + 1))
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_init,
    output logic                      init_busy,
    output logic                      init_done,
    input  logic                      cell_valid,
    output logic                      cell_ready,
    input  logic [ROW_W-1:0]          i,
    input  logic [COL_W-1:0]          j,
    input  logic signed [SCORE_W-1:0] max,
    output logic                      we,
    output logic [ADDR_W-1:0]         addr_out,
    output logic signed [SCORE_W-1:0] data_out,
    output logic                      err
);

    localparam logic signed [SCORE_W-1:0] GAP_S  = SCORE_W'(GAP);
    localparam logic [COL_W-1:0]          C_LAST = COL_W'(M);
    localparam logic [ROW_W-1:0]          R_LAST = ROW_W'(N);

    wr_state_t                 state_q, state_d;
    logic [COL_W-1:0]          c_q, c_d;
    logic [ROW_W-1:0]          r_q, r_d;
    logic signed [SCORE_W-1:0] acc_q, acc_d;
    logic                      err_q, err_d;
    logic                      we_d, done_d;
    logic signed [SCORE_W-1:0] data_d;
    logic [ROW_W:0]            calc_row;
    logic [COL_W:0]            calc_col;
    logic [ADDR_W-1:0]         calc_addr;
    logic                      oob;

    logic                      we_q, done_q;
    logic [ADDR_W-1:0]         addr_q;
    logic signed [SCORE_W-1:0] data_q;

`ifdef SCORE_WR_BOUNDS_CHK_EN
    assign oob = (int'(i) >= N) || (int'(j) >= M);
`else
    assign oob = 1'b0;
`endif

    score_addr_calc #(
        .M      (M),
        .ROW_W  (ROW_W),
        .COL_W  (COL_W),
        .ADDR_W (ADDR_W)
    ) u_addr (
        .row  (calc_row),
        .col  (calc_col),
        .addr (calc_addr)
    );

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        r_d      = r_q;
        acc_d    = acc_q;
        err_d    = err_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        data_d   = '0;
        calc_row = '0;
        calc_col = '0;
        case (state_q)
            IDLE: begin
                if (start_init) begin
                    state_d = INIT_ROW;
                    c_d     = '0;
                    acc_d   = '0;
                end
            end
            INIT_ROW: begin
                we_d     = 1'b1;
                calc_col = {1'b0, c_q};
                data_d   = acc_q;
                if (c_q == C_LAST) begin
                    state_d = INIT_COL;
                    r_d     = ROW_W'(1);
                    acc_d   = GAP_S;
                end else begin
                    c_d   = c_q + COL_W'(1);
                    acc_d = acc_q + GAP_S;
                end
            end
            INIT_COL: begin
                we_d     = 1'b1;
                calc_row = {1'b0, r_q};
                data_d   = acc_q;
                if (r_q == R_LAST) begin
                    state_d = RUN;
                    done_d  = 1'b1;
                end else begin
                    r_d   = r_q + ROW_W'(1);
                    acc_d = acc_q + GAP_S;
                end
            end
            RUN: begin
                if (cell_valid) begin
                    // Cell (i, j) lives one row and one column past the boundary.
                    calc_row = {1'b0, i} + (ROW_W + 1)'(1);
                    calc_col = {1'b0, j} + (COL_W + 1)'(1);
                    if (oob) begin
                        err_d = 1'b1;
                    end else begin
                        we_d   = 1'b1;
                        data_d = max;
                    end
                end
                if (start_init) begin
                    state_d = INIT_ROW;
                    c_d     = '0;
                    acc_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            r_q     <= r_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            we_q    <= we_d;
            done_q  <= done_d;
            addr_q  <= we_d ? calc_addr : '0;
            data_q  <= data_d;
        end
    end

    assign init_busy  = (state_q == INIT_ROW) || (state_q == INIT_COL);
    assign cell_ready = (state_q == RUN);
    assign init_done  = done_q;
    assign we         = we_q;
    assign addr_out   = addr_q;
    assign data_out   = data_q;
    assign err        = err_q;

endmodule

// File: tb/tb_score_ram_writer.sv
// Randomized self-checking bench for score_ram_writer against an arithmetic reference model.
module tb_score_ram_writer;

    localparam int N    = 4;
    localparam int M    = 3;
    localparam int SW   = 9;
    localparam int GAP  = -2;
    localparam int RW   = $clog2(N + 1);
    localparam int CW   = $clog2(M + 1);
    localparam int AW   = $clog2((N + 1) * (M + 1));
    localparam int N2   = 3;
    localparam int M2   = 1;
    localparam int GAP2 = -100;
    localparam int RW2  = $clog2(N2 + 1);
    localparam int CW2  = $clog2(M2 + 1);
    localparam int AW2  = $clog2((N2 + 1) * (M2 + 1));

    logic clk, rst;
    logic start_init, init_busy, init_done, cell_valid, cell_ready, we, err;
    logic [RW-1:0] i;
    logic [CW-1:0] j;
    logic signed [SW-1:0] max, data_out;
    logic [AW-1:0] addr_out;

    logic start2, busy2, done2, valid2, ready2, we2, err2;
    logic [RW2-1:0] i2;
    logic [CW2-1:0] j2;
    logic signed [SW-1:0] max2, data2;
    logic [AW2-1:0] addr2;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_err = 0;

    score_ram_writer #(.N(N), .M(M), .SCORE_W(SW), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .start_init(start_init), .init_busy(init_busy),
        .init_done(init_done), .cell_valid(cell_valid), .cell_ready(cell_ready),
        .i(i), .j(j), .max(max), .we(we), .addr_out(addr_out),
        .data_out(data_out), .err(err)
    );

    score_ram_writer #(.N(N2), .M(M2), .SCORE_W(SW), .GAP(GAP2)) dut2 (
        .clk(clk), .rst(rst), .start_init(start2), .init_busy(busy2),
        .init_done(done2), .cell_valid(valid2), .cell_ready(ready2),
        .i(i2), .j(j2), .max(max2), .we(we2), .addr_out(addr2),
        .data_out(data2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int wrap(input int v);
        logic signed [SW-1:0] t;
        t = v[SW-1:0];
        return int'(t);
    endfunction

    // n-th boundary write: row 0 left to right, then column 0 top to bottom.
    function automatic int init_addr(input int n, input int mm);
        return (n <= mm) ? n : (n - mm) * (mm + 1);
    endfunction

    function automatic int init_data(input int n, input int mm, input int g);
        return wrap(((n <= mm) ? n : n - mm) * g);
    endfunction

    function automatic int cell_addr(input int ci, input int cj);
        return ((ci + 1) * (M + 1) + cj + 1) % (1 << AW);
    endfunction

    task automatic do_cell(input bit v, input int ci, input int cj, input int cmax);
        cell_valid = v;
        i   = RW'(ci);
        j   = CW'(cj);
        max = SW'(cmax);
        tick();
        chk("cell_we",    int'(we),       v ? 1 : 0);
        chk("cell_addr",  int'(addr_out), v ? cell_addr(ci, cj) : 0);
        chk("cell_data",  int'(data_out), v ? cmax : 0);
        chk("cell_ready", int'(cell_ready), 1);
        chk("cell_err",   int'(err),      exp_err);
    endtask

    task automatic do_init(input bit hold_valid, input bit pulse_mid, input bit with_cell,
                           input int ci, input int cj, input int cmax);
        start_init = 1'b1;
        if (with_cell) begin
            cell_valid = 1'b1;
            i   = RW'(ci);
            j   = CW'(cj);
            max = SW'(cmax);
        end
        tick();
        start_init = 1'b0;
        chk("start_we",   int'(we),       with_cell ? 1 : 0);
        chk("start_addr", int'(addr_out), with_cell ? cell_addr(ci, cj) : 0);
        chk("start_data", int'(data_out), with_cell ? cmax : 0);
        chk("start_busy", int'(init_busy), 1);
        cell_valid = hold_valid;
        if (hold_valid) begin
            i   = RW'($urandom_range(0, N - 1));
            j   = CW'($urandom_range(0, M - 1));
            max = SW'($urandom_range(0, 511));
        end
        for (int n = 0; n <= N + M; n++) begin
            if (pulse_mid && n == 2) start_init = 1'b1;
            tick();
            start_init = 1'b0;
            chk("init_we",    int'(we),         1);
            chk("init_addr",  int'(addr_out),   init_addr(n, M));
            chk("init_data",  int'(data_out),   init_data(n, M, GAP));
            chk("init_done",  int'(init_done),  (n == N + M) ? 1 : 0);
            chk("init_busy",  int'(init_busy),  (n < N + M) ? 1 : 0);
            chk("init_ready", int'(cell_ready), (n == N + M) ? 1 : 0);
            if (n == N + M) cell_valid = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        start_init = 1'b0; cell_valid = 1'b0; i = '0; j = '0; max = '0;
        start2 = 1'b0; valid2 = 1'b0; i2 = '0; j2 = '0; max2 = '0;
        tick();
        tick();
        chk("rst_we",    int'(we), 0);
        chk("rst_addr",  int'(addr_out), 0);
        chk("rst_data",  int'(data_out), 0);
        chk("rst_busy",  int'(init_busy), 0);
        chk("rst_done",  int'(init_done), 0);
        chk("rst_err",   int'(err), 0);
        chk("rst_ready", int'(cell_ready), 0);
        rst = 1'b0;

        cell_valid = 1'b1;
        tick();
        chk("idle_we",    int'(we), 0);
        chk("idle_ready", int'(cell_ready), 0);
        cell_valid = 1'b0;

        do_init(1'b1, 1'b1, 1'b0, 0, 0, 0);

        do_cell(1'b1, 1, 2, 5);
        do_cell(1'b1, 0, 0, 7);
        do_cell(1'b1, 3, 2, -1);
        do_cell(1'b0, 0, 0, 0);
        for (int k = 0; k < 40; k++)
            do_cell(($urandom_range(0, 3) != 0), $urandom_range(0, N - 1),
                    $urandom_range(0, M - 1), $urandom_range(0, 511) - 256);

        do_init(1'b0, 1'b0, 1'b1, 2, 1, -9);

        cell_valid = 1'b1; i = RW'(4); j = CW'(2); max = SW'(9);
        tick();
`ifdef SCORE_WR_BOUNDS_CHK_EN
        chk("oob_we",  int'(we), 0);
        chk("oob_err", int'(err), 1);
        exp_err = 1;
`else
        chk("oob_we",   int'(we), 1);
        chk("oob_addr", int'(addr_out), cell_addr(4, 2));
        chk("oob_err",  int'(err), 0);
`endif
        for (int k = 0; k < 10; k++)
            do_cell(($urandom_range(0, 3) != 0), $urandom_range(0, N - 1),
                    $urandom_range(0, M - 1), $urandom_range(0, 511) - 256);
        cell_valid = 1'b0;

        start_init = 1'b1;
        tick();
        start_init = 1'b0;
        for (int k = 0; k < M + 2; k++) tick();
        chk("pre_rst_addr", int'(addr_out), init_addr(M + 1, M));
        rst = 1'b1;
        tick();
        chk("mid_rst_we",    int'(we), 0);
        chk("mid_rst_addr",  int'(addr_out), 0);
        chk("mid_rst_data",  int'(data_out), 0);
        chk("mid_rst_busy",  int'(init_busy), 0);
        chk("mid_rst_done",  int'(init_done), 0);
        chk("mid_rst_err",   int'(err), 0);
        chk("mid_rst_ready", int'(cell_ready), 0);
        exp_err = 0;
        rst = 1'b0;
        cell_valid = 1'b1;
        tick();
        chk("post_rst_we", int'(we), 0);
        cell_valid = 1'b0;
        do_init(1'b0, 1'b0, 1'b0, 0, 0, 0);
        do_cell(1'b1, 2, 1, 33);

        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int n = 0; n <= N2 + M2; n++) begin
            tick();
            chk("wrap_we",   int'(we2), 1);
            chk("wrap_addr", int'(addr2), init_addr(n, M2));
            chk("wrap_data", int'(data2), init_data(n, M2, GAP2));
            chk("wrap_done", int'(done2), (n == N2 + M2) ? 1 : 0);
            if (n == N2 + M2) chk("wrap_212", int'(data2), 212);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
